vaddr_xlate_unit: RTL and testbench
===================================

# vaddr_xlate_unit

Registered, programmable virtual-to-physical address translator sitting between the core's address generation (IF/MEM stage) and the instruction/data memory ports. It matches the upper address bits against an NSEG-entry segment table, subtracts the segment base, checks alignment and segment limit, and returns the physical address one cycle later over a valid/ready handshake. The table resets to the standard MIPS text/data layout and can be rewritten at run time through a config port; faults are flagged per response and counted.

## Interface
- ADDR_W, 32, address width (virtual and physical)
- TAG_W, 12, number of upper vaddr bits compared per segment
- NSEG, 4, segment table entries (≥2)
- PASS_UNMAPPED, 1, 1: miss passes vaddr through unfaulted; 0: miss faults
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  translation request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_vaddr  in  ADDR_W  virtual address
- req_size  in  2  0 byte, 1 halfword, 2 word, 3 reserved (faults)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_addr  out  ADDR_W  physical address
- rsp_hit  out  1  a segment matched
- rsp_seg  out  $clog2(NSEG)  matched segment index (0 on miss)
- rsp_fault  out  1  misaligned, reserved size, limit violation, or unmapped miss
- cfg_we  in  1  segment table write strobe
- cfg_idx  in  $clog2(NSEG)  entry to write
- cfg_en  in  1  entry valid bit
- cfg_tag  in  TAG_W  match value
- cfg_base  in  ADDR_W  subtracted base
- cfg_limit  in  ADDR_W  exclusive upper bound on (vaddr − base); 0 = unlimited
- cnt_clr  in  1  clear fault counter
- fault_cnt  out  16  saturating count of faulted responses

## Operation
- Match: entry i hits when en[i] && req_vaddr[ADDR_W-1 -: TAG_W] == tag[i]; lowest hitting index wins.
- Hit: addr = req_vaddr − base[i], modulo 2^ADDR_W; fault if limit[i] != 0 && addr ≥ limit[i].
- Miss: addr = req_vaddr, hit=0, seg=0; fault = !PASS_UNMAPPED.
- Alignment: fault if size=1 && vaddr[0], size=2 && vaddr[1:0]!=0, or size=3. Address still computed normally. Fault sources OR together.
- Reset table: entry0 en=1, tag=0x004, base=0x0040_0000; entry1 en=1, tag=0x100, base=0x1001_0000; entries ≥2 en=0, tag/base 0; all limits 0.
- Config: cfg_we writes entry cfg_idx (all four fields) at the clock edge; cfg_idx ≥ NSEG is ignored. Request accepted in the same cycle as a cfg write uses the old table.
- fault_cnt: +1 on each accepted request whose result faults; saturates at 0xFFFF; cnt_clr wins over simultaneous increment (result 0).

## Timing
- Single output register stage; latency 1 cycle from acceptance to rsp_valid.
- req_ready = !rsp_valid || rsp_ready (combinational); back-to-back full throughput with rsp_ready held 1.
- Response fields stable while rsp_valid && !rsp_ready; accepted request overwrites register on the edge where the previous response is taken.
- rsp_valid falls the cycle after rsp_ready when no new request accepted.
- Reset values: rsp_valid 0, rsp_addr 0, rsp_hit 0, rsp_seg 0, rsp_fault 0, fault_cnt 0, table to defaults. Reset mid-transfer drops the pending response; no request is accepted in the reset cycle.

## Test plan
- Post-reset, word req 0x0040_0010 → next cycle rsp_addr 0x0000_0010, hit=1, seg=0, fault=0; req 0x1001_0008 → 0x0000_0008, seg=1.
- Miss 0x7FFF_EFFC, PASS_UNMAPPED=1 → addr 0x7FFF_EFFC, hit=0, fault=0, fault_cnt unchanged; PASS_UNMAPPED=0 build → fault=1, fault_cnt=1.
- Halfword req 0x0040_0003 → fault=1, addr 0x0000_0003; size=3 any addr → fault=1.
- cfg write idx2 tag 0x800 base 0x8000_0000 limit 0x100; req 0x8000_00FC → 0xFC no fault; 0x8000_0100 → fault; same-cycle cfg write to idx0 with request 0x0040_0000 → old mapping 0x0.
- Hold rsp_ready=0 three cycles with req_valid=1 → req_ready=0, rsp fields stable; release → stream resumes, no request lost or duplicated.
- Force 65 536 faults → fault_cnt 0xFFFF stays; cnt_clr with concurrent fault → 0; rst asserted with rsp_valid=1 → rsp_valid 0 next cycle.

Source files
------------

// File: rtl/vaddr_xlate_unit.sv
// Virtual-to-physical address translator: segment-table match, base subtract,
// alignment/limit checks, one registered response stage with valid/ready.
module vaddr_xlate_seg #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 12
) (
  input  logic              en,
  input  logic [TAG_W-1:0]  tag,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  input  logic [ADDR_W-1:0] vaddr,
  output logic              hit,
  output logic [ADDR_W-1:0] addr,
  output logic              over
);
  assign hit  = en && (vaddr[ADDR_W-1 -: TAG_W] == tag);
  assign addr = vaddr - base;
  // A zero limit means the segment has no upper bound.
  assign over = (limit != '0) && (addr >= limit);
endmodule

module vaddr_xlate_unit #(
  parameter int ADDR_W        = 32,
  parameter int TAG_W         = 12,
  parameter int NSEG          = 4,
  parameter bit PASS_UNMAPPED = 1'b1,
  localparam int SEG_W        = $clog2(NSEG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_vaddr,
  input  logic [1:0]        req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_hit,
  output logic [SEG_W-1:0]  rsp_seg,
  output logic              rsp_fault,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [TAG_W-1:0]  cfg_tag,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic              cnt_clr,
  output logic [15:0]       fault_cnt
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [SEG_W-1:0]  seg;
    logic              fault;
  } rsp_t;

  logic [NSEG-1:0]             seg_en;
  logic [NSEG-1:0][TAG_W-1:0]  seg_tag;
  logic [NSEG-1:0][ADDR_W-1:0] seg_base, seg_limit;
  logic [NSEG-1:0]             hit_vec, over_vec;
  logic [NSEG-1:0][ADDR_W-1:0] off_vec;
  rsp_t                        nxt, rsp_q;
  logic                        misalign, accept;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    vaddr_xlate_seg #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) u_seg (
      .en(seg_en[g]), .tag(seg_tag[g]), .base(seg_base[g]), .limit(seg_limit[g]),
      .vaddr(req_vaddr), .hit(hit_vec[g]), .addr(off_vec[g]), .over(over_vec[g])
    );
  end

  assign misalign = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_vaddr[0]) ||
                    (req_size == 2'd2 && req_vaddr[1:0] != 2'b00);

  always_comb begin
    nxt.addr  = req_vaddr;
    nxt.hit   = 1'b0;
    nxt.seg   = '0;
    nxt.fault = !PASS_UNMAPPED;
    // Walk downward so the lowest hitting index is the last writer.
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        nxt.addr  = off_vec[i];
        nxt.hit   = 1'b1;
        nxt.seg   = SEG_W'(i);
        nxt.fault = over_vec[i];
      end
    end
    nxt.fault = nxt.fault | misalign;
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        seg_en[i]    <= 1'b0;
        seg_tag[i]   <= '0;
        seg_base[i]  <= '0;
        seg_limit[i] <= '0;
      end
      seg_en[0]   <= 1'b1;
      seg_tag[0]  <= TAG_W'('h004);
      seg_base[0] <= ADDR_W'('h0040_0000);
      seg_en[1]   <= 1'b1;
      seg_tag[1]  <= TAG_W'('h100);
      seg_base[1] <= ADDR_W'('h1001_0000);
    end else if (cfg_we && 32'(cfg_idx) < NSEG) begin
      seg_en[cfg_idx]    <= cfg_en;
      seg_tag[cfg_idx]   <= cfg_tag;
      seg_base[cfg_idx]  <= cfg_base;
      seg_limit[cfg_idx] <= cfg_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_q     <= nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      fault_cnt <= '0;
    else if (accept && nxt.fault && fault_cnt != 16'hFFFF)
      fault_cnt <= fault_cnt + 16'd1;
  end

  assign rsp_addr  = rsp_q.addr;
  assign rsp_hit   = rsp_q.hit;
  assign rsp_seg   = rsp_q.seg;
  assign rsp_fault = rsp_q.fault;
endmodule

// File: tb/tb_vaddr_xlate_unit.sv
// Directed bench for vaddr_xlate_unit: vector table plus handshake, config,
// counter-saturation and reset sequences; a second strict instance covers misses.
module tb_vaddr_xlate_unit;
  logic        clk = 1'b0;
  logic        rst, req_valid, rsp_ready, cfg_we, cfg_en, cnt_clr;
  logic [31:0] req_vaddr, cfg_base, cfg_limit;
  logic [1:0]  req_size, cfg_idx;
  logic [11:0] cfg_tag;

  logic        req_ready, rsp_valid, rsp_hit, rsp_fault;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_seg;
  logic [15:0] fault_cnt;

  logic        s_req_ready, s_rsp_valid, s_rsp_hit, s_rsp_fault;
  logic [31:0] s_rsp_addr;
  logic [1:0]  s_rsp_seg;
  logic [15:0] s_fault_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  vaddr_xlate_unit #(.PASS_UNMAPPED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_size(req_size), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit), .rsp_seg(rsp_seg),
    .rsp_fault(rsp_fault), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_tag(cfg_tag), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cnt_clr(cnt_clr), .fault_cnt(fault_cnt)
  );

  vaddr_xlate_unit #(.PASS_UNMAPPED(1'b0)) u_strict (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_vaddr(req_vaddr), .req_size(req_size), .rsp_valid(s_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_addr(s_rsp_addr), .rsp_hit(s_rsp_hit), .rsp_seg(s_rsp_seg),
    .rsp_fault(s_rsp_fault), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_tag(cfg_tag), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cnt_clr(cnt_clr), .fault_cnt(s_fault_cnt)
  );

  typedef struct {
    logic [31:0] vaddr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        hit;
    logic [1:0]  seg;
    logic        fault;
  } vec_t;

  localparam int NVEC_A = 11;
  localparam int NVEC   = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string name, input logic [31:0] addr, input logic hit,
                           input logic [1:0] seg, input logic fault);
    check({name, ".valid"}, 32'(rsp_valid), 32'd1);
    check({name, ".addr"},  rsp_addr, addr);
    check({name, ".hit"},   32'(rsp_hit), 32'(hit));
    check({name, ".seg"},   32'(rsp_seg), 32'(seg));
    check({name, ".fault"}, 32'(rsp_fault), 32'(fault));
  endtask

  // Present one request with rsp_ready held high; check its response next cycle.
  task automatic apply_vec(input int i);
    req_valid = 1'b1;
    req_vaddr = vecs[i].vaddr;
    req_size  = vecs[i].size;
    @(posedge clk); #1;
    if (vecs[i].fault) exp_cnt++;
    check_rsp($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hit, vecs[i].seg, vecs[i].fault);
    check($sformatf("vec%0d.cnt", i), 32'(fault_cnt), 32'(exp_cnt));
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [11:0] tag,
                           input logic [31:0] base, input logic [31:0] limit);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_tag = tag;
    cfg_base = base; cfg_limit = limit;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    // Default-table vectors, then vectors against the reprogrammed entry 2.
    vecs[0]  = '{32'h0040_0010, 2'd2, 32'h0000_0010, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{32'h1001_0008, 2'd2, 32'h0000_0008, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{32'h7FFF_EFFC, 2'd2, 32'h7FFF_EFFC, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{32'h0040_0003, 2'd1, 32'h0000_0003, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{32'h1001_0002, 2'd3, 32'h0000_0002, 1'b1, 2'd1, 1'b1};
    vecs[5]  = '{32'h0040_0002, 2'd2, 32'h0000_0002, 1'b1, 2'd0, 1'b1};
    vecs[6]  = '{32'h0040_0002, 2'd1, 32'h0000_0002, 1'b1, 2'd0, 1'b0};
    vecs[7]  = '{32'h0040_0001, 2'd0, 32'h0000_0001, 1'b1, 2'd0, 1'b0};
    vecs[8]  = '{32'h004F_FFFF, 2'd0, 32'h000F_FFFF, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{32'h0050_0000, 2'd2, 32'h0050_0000, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{32'h1000_FFFC, 2'd2, 32'hFFFF_FFFC, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{32'h8000_00FC, 2'd2, 32'h0000_00FC, 1'b1, 2'd2, 1'b0};
    vecs[12] = '{32'h8000_0100, 2'd2, 32'h0000_0100, 1'b1, 2'd2, 1'b1};
    vecs[13] = '{32'h8000_00FF, 2'd0, 32'h0000_00FF, 1'b1, 2'd2, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_size = '0; rsp_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_tag = '0; cfg_base = '0;
    cfg_limit = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.addr",  rsp_addr, 32'd0);
    check("rst.hit",   32'(rsp_hit), 32'd0);
    check("rst.seg",   32'(rsp_seg), 32'd0);
    check("rst.fault", 32'(rsp_fault), 32'd0);
    check("rst.cnt",   32'(fault_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);

    // Miss: pass-through build stays clean, strict build faults and counts.
    req_valid = 1'b1; req_vaddr = 32'h7FFF_EFFC; req_size = 2'd2;
    @(posedge clk); #1;
    check_rsp("miss", 32'h7FFF_EFFC, 1'b0, 2'd0, 1'b0);
    check("miss.cnt",          32'(fault_cnt), 32'd0);
    check("strict.addr",       s_rsp_addr, 32'h7FFF_EFFC);
    check("strict.fault",      32'(s_rsp_fault), 32'd1);
    check("strict.cnt",        32'(s_fault_cnt), 32'd1);

    // Back-to-back stream through the default table.
    for (int i = 0; i < NVEC_A; i++) apply_vec(i);
    req_valid = 1'b0;

    cfg_write(2'd2, 1'b1, 12'h800, 32'h8000_0000, 32'h0000_0100);
    for (int i = NVEC_A; i < NVEC; i++) apply_vec(i);
    req_valid = 1'b0;

    // Config write and request in the same cycle: request sees the old table.
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_tag = 12'h004;
    cfg_base = 32'h0030_0000; cfg_limit = '0;
    req_valid = 1'b1; req_vaddr = 32'h0040_0000; req_size = 2'd2;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check_rsp("samecyc.old", 32'h0000_0000, 1'b1, 2'd0, 1'b0);
    @(posedge clk); #1;
    check_rsp("samecyc.new", 32'h0010_0000, 1'b1, 2'd0, 1'b0);
    req_valid = 1'b0;

    // Lowest index wins; disabling entry 0 exposes entry 3.
    cfg_write(2'd3, 1'b1, 12'h004, 32'h0000_0000, 32'h0);
    req_valid = 1'b1; req_vaddr = 32'h0040_0004;
    @(posedge clk); #1;
    check_rsp("prio.seg0", 32'h0010_0004, 1'b1, 2'd0, 1'b0);
    req_valid = 1'b0;
    cfg_write(2'd0, 1'b0, 12'h004, 32'h0030_0000, 32'h0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    check_rsp("prio.seg3", 32'h0040_0004, 1'b1, 2'd3, 1'b0);

    // Backpressure: response held, request stalled, then stream resumes.
    req_vaddr = 32'h1001_0010;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_vaddr = 32'h1001_0020;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_rsp($sformatf("stall%0d", k), 32'h0000_0010, 1'b1, 2'd1, 1'b0);
      check($sformatf("stall%0d.ready", k), 32'(req_ready), 32'd0);
      @(posedge clk);
    end
    #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_rsp("resume.b", 32'h0000_0020, 1'b1, 2'd1, 1'b0);
    req_vaddr = 32'h1001_0030;
    @(posedge clk); #1;
    check_rsp("resume.c", 32'h0000_0030, 1'b1, 2'd1, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("drain.valid", 32'(rsp_valid), 32'd0);

    // Counter saturation, then clear racing a fault.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr.cnt", 32'(fault_cnt), 32'd0);
    req_valid = 1'b1; req_vaddr = 32'h0; req_size = 2'd3;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", 32'(fault_cnt), 32'h0000_FFFE);
    repeat (6) @(posedge clk);
    #1;
    check("sat.ffff", 32'(fault_cnt), 32'h0000_FFFF);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clrwin.cnt",   32'(fault_cnt), 32'd0);
    check("clrwin.fault", 32'(rsp_fault), 32'd1);

    // Reset with a response pending drops it and restores the default table.
    check("prerst.valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.valid", 32'(rsp_valid), 32'd0);
    check("midrst.addr",  rsp_addr, 32'd0);
    rst = 1'b0; req_vaddr = 32'h0040_0010; req_size = 2'd2;
    @(posedge clk); #1;
    check_rsp("postrst", 32'h0000_0010, 1'b1, 2'd0, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
